// File: rtl/spi_bridge_pkg.sv
// Shared constants and FSM state type for the SPI master streaming bridge.
// Register map of the on-chip 8-bit SPI master slave port.
package spi_bridge_pkg;

    localparam logic [2:0] ADDR_RXDATA   = 3'd0;
    localparam logic [2:0] ADDR_TXDATA   = 3'd1;
    localparam logic [2:0] ADDR_STATUS   = 3'd2;
    localparam logic [2:0] ADDR_CONTROL  = 3'd3;
    localparam logic [2:0] ADDR_SLAVESEL = 3'd5;

    localparam int CTRL_SSO_BIT = 10;

    typedef enum logic [2:0] {
        IDLE,
        RD1,
        RD2,
        WR1,
        WR2,
        GAP,
        CT1,
        CT2
    } state_t;

endpackage

// File: rtl/sync_fifo.sv
// 8-bit first-word-fall-through FIFO with occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     i_push,
    input  logic [7:0]               i_wdata,
    input  logic                     i_pop,
    output logic [7:0]               o_rdata,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_full;
    logic          w_push;
    logic          w_pop;

    assign w_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rd_ptr];

    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_push = i_push && (!w_full || i_pop);
    assign w_pop  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/spi_stream_bridge.sv
// Streams bytes to/from the SPI master's slave port via txdata/rxdata.
// Optional SPI_BRIDGE_CS_HOLD_EN adds cs_hold and control-register writes.
module spi_stream_bridge
    import spi_bridge_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic        spi_select,
    output logic [2:0]  mem_addr,
    output logic        read_n,
    output logic        write_n,
    output logic [15:0] spi_wdata,
    input  logic [15:0] spi_rdata,
    input  logic        dataavailable,
    input  logic        readyfordata,
    output logic        busy
`ifdef SPI_BRIDGE_CS_HOLD_EN
    ,
    input  logic        cs_hold
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] LIM = (CW+1)'(DEPTH);

    state_t        r_state;
    logic          r_select;
    logic [2:0]    r_addr;
    logic          r_read_n;
    logic          r_write_n;
    logic [15:0]   r_wdata;
    logic [1:0]    r_inflight;

    logic [CW-1:0] w_tx_count;
    logic [CW-1:0] w_rx_count;
    logic          w_tx_empty;
    logic          w_rx_empty;
    logic [7:0]    w_tx_head;
    logic          w_tx_push;
    logic          w_rx_pop;
    logic [CW:0]   w_credit;
    logic          w_wr_ok;
    logic          w_inc;
    logic          w_dec;
    logic [7:0]    w_unused_rdata;

    assign w_unused_rdata = spi_rdata[15:8];

    assign tx_ready  = (w_tx_count != CW'(DEPTH));
    assign w_tx_push = tx_valid && tx_ready;
    assign rx_valid  = !w_rx_empty;
    assign w_rx_pop  = rx_valid && rx_ready;

    sync_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (w_tx_push),
        .i_wdata (tx_data),
        .i_pop   (r_state == WR2),
        .o_rdata (w_tx_head),
        .o_empty (w_tx_empty),
        .o_count (w_tx_count)
    );

    sync_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (r_state == RD2),
        .i_wdata (spi_rdata[7:0]),
        .i_pop   (w_rx_pop),
        .o_rdata (rx_data),
        .o_empty (w_rx_empty),
        .o_count (w_rx_count)
    );

    // Credit: every byte sent must already own a slot in the RX FIFO.
    assign w_credit = {1'b0, w_rx_count} + (CW+1)'(r_inflight);
    assign w_wr_ok  = readyfordata && !w_tx_empty
                   && (w_credit < LIM) && (r_inflight < 2'd2);

    assign w_inc = (r_state == WR2);
    assign w_dec = (r_state == RD2);
    assign busy  = !w_tx_empty || (r_inflight != 2'd0);

`ifdef SPI_BRIDGE_CS_HOLD_EN
    logic r_cs_last;
    logic w_ct_ok;
    assign w_ct_ok = (cs_hold != r_cs_last) && (r_inflight == 2'd0);
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_inflight <= 2'd0;
        end else begin
            case ({w_inc, w_dec})
                2'b10:   r_inflight <= r_inflight + 2'd1;
                2'b01:   r_inflight <= r_inflight - 2'd1;
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_select  <= 1'b0;
            r_addr    <= 3'd0;
            r_read_n  <= 1'b1;
            r_write_n <= 1'b1;
            r_wdata   <= 16'h0000;
`ifdef SPI_BRIDGE_CS_HOLD_EN
            r_cs_last <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    // Reads win so a pending RRDY is drained before ROE.
                    if (dataavailable) begin
                        r_state  <= RD1;
                        r_select <= 1'b1;
                        r_addr   <= ADDR_RXDATA;
                        r_read_n <= 1'b0;
                    end
`ifdef SPI_BRIDGE_CS_HOLD_EN
                    else if (w_ct_ok) begin
                        r_state   <= CT1;
                        r_select  <= 1'b1;
                        r_addr    <= ADDR_CONTROL;
                        r_write_n <= 1'b0;
                        r_wdata   <= {15'd0, cs_hold} << CTRL_SSO_BIT;
                        r_cs_last <= cs_hold;
                    end
`endif
                    else if (w_wr_ok) begin
                        r_state   <= WR1;
                        r_select  <= 1'b1;
                        r_addr    <= ADDR_TXDATA;
                        r_write_n <= 1'b0;
                        r_wdata   <= {8'h00, w_tx_head};
                    end
                end
                RD1: r_state <= RD2;
                WR1: r_state <= WR2;
`ifdef SPI_BRIDGE_CS_HOLD_EN
                CT1: r_state <= CT2;
                CT2: begin
                    r_state   <= GAP;
                    r_select  <= 1'b0;
                    r_addr    <= 3'd0;
                    r_write_n <= 1'b1;
                    r_wdata   <= 16'h0000;
                end
`endif
                RD2, WR2: begin
                    r_state   <= GAP;
                    r_select  <= 1'b0;
                    r_addr    <= 3'd0;
                    r_read_n  <= 1'b1;
                    r_write_n <= 1'b1;
                    r_wdata   <= 16'h0000;
                end
                GAP:     r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign spi_select = r_select;
    assign mem_addr   = r_addr;
    assign read_n     = r_read_n;
    assign write_n    = r_write_n;
    assign spi_wdata  = r_wdata;

endmodule

// File: doc/spi_stream_bridge.md
# spi_stream_bridge

Streaming front-end for the on-chip 8-bit SPI master (register map: 0 rxdata, 1 txdata, 2 status, 3 control, 5 slave-select). It replaces CPU polling. Upstream logic pushes bytes into a TX FIFO, and the bridge issues two-cycle register writes to the SPI master's txdata whenever `readyfordata` is high. It reads each received byte back via rxdata when `dataavailable` is high and presents it on a valid/ready RX stream. It drives the SPI master's slave port directly, in place of the CPU.

## Interface
- `DEPTH`, 16, entries per FIFO (TX and RX); power of two, ≥4.
- `clk` in 1, system clock (same clock as the SPI master).
- `reset_n` in 1, reset, asynchronous and active-low.
- `tx_data` in 8, byte to transmit.
- `tx_valid` in 1, tx_data valid.
- `tx_ready` out 1, TX FIFO not full.
- `rx_data` out 8, received byte (head of RX FIFO).
- `rx_valid` out 1, RX FIFO not empty.
- `rx_ready` in 1, consumer accepts rx_data.
- `spi_select` out 1, chip-select to the SPI master slave port.
- `mem_addr` out 3, register address.
- `read_n` out 1, active-low read.
- `write_n` out 1, active-low write.
- `spi_wdata` out 16, write data (drives SPI master `data_from_cpu`).
- `spi_rdata` in 16, read data (from SPI master `data_to_cpu`).
- `dataavailable` in 1, SPI master RRDY.
- `readyfordata` in 1, SPI master TRDY.
- `busy` out 1, TX FIFO non-empty or `inflight` ≠ 0.
- `cs_hold` in 1 (only with SPI_BRIDGE_CS_HOLD_EN), requested SSO level.

## Operation
- FIFOs:
  - A push occurs on `tx_valid & tx_ready`; a pop on `rx_valid & rx_ready`.
  - FIFO data are first-word fall-through; counts are $clog2(DEPTH)+1 bits wide.
- `inflight` counter (0..3): counts bytes written to the SPI master but not yet read back.
  - Increments at the end of WR2 and decrements at the end of RD2.
  - If both occur in the same cycle, it is unchanged (not possible in a single FSM, but the counter logic must handle it).
- FSM states: IDLE, RD1, RD2, WR1, WR2, GAP (plus CT1, CT2 with the macro).
  - IDLE → RD1 if `dataavailable`. Read has priority over write, which prevents ROE.
  - IDLE → WR1 if all of: `readyfordata`, TX FIFO non-empty, `rx_count + inflight < DEPTH`, `inflight < 2`. This credit rule guarantees every received byte has RX space.
  - RD1/WR1 → RD2/WR2 unconditionally. Both bus cycles hold identical `spi_select`, `mem_addr`, `read_n`/`write_n` and `spi_wdata`.
  - RD2: `spi_rdata[7:0]` is pushed into the RX FIFO at the end of the cycle.
  - WR2: the TX FIFO pops at the end of the cycle; `spi_wdata = {8'h00, tx_head}`.
  - RD2/WR2 → GAP → IDLE. GAP deasserts the bus for one cycle so the SPI master's strobe register clears and stale RRDY/TRDY are not re-sampled.
- Idle bus values: `spi_select=0`, `read_n=1`, `write_n=1`, `mem_addr=0`, `spi_wdata=0`.
- All bus outputs are registered; no combinational path from stream inputs to bus outputs.

## Timing
- Reset values: FSM IDLE, FIFOs empty, `inflight=0`, `tx_ready=1`, `rx_valid=0`, `busy=0`, bus outputs at idle values.
- Reset mid-access aborts immediately and the bus returns to idle. The SPI master is reset by the same `reset_n`.
- One SPI master access takes 3 cycles (2 bus cycles + GAP). Maximum one register access per 3 cycles.
- TX push to first WR1: 2 cycles minimum (FIFO write, then IDLE decision).
- `dataavailable` high in IDLE at cycle N: RD1 at N+1; byte appears on `rx_valid` at N+3.
- Full TX FIFO: `tx_ready=0`; a push attempt is ignored. Simultaneous push and pop when full is permitted (pop frees the slot in the same cycle).
- Empty RX FIFO: `rx_ready` is ignored.
- Pointers wrap modulo DEPTH.

## Configuration
- `SPI_BRIDGE_CS_HOLD_EN` defined:
  - Adds the `cs_hold` port and states CT1/CT2.
  - When `cs_hold` differs from the last written value and the bridge is in IDLE with `inflight==0`, the bridge writes control (addr 3, `spi_wdata = cs_hold<<10`) before any new WR1.
  - CT1 → CT2 → GAP. The last-written value resets to 0.
- Undefined: no port, no control writes; SS_n is governed solely by the SPI master's per-transfer enable.

## Structure
- Package `spi_bridge_pkg`:
  - Address constants `ADDR_RXDATA=0`, `ADDR_TXDATA=1`, `ADDR_STATUS=2`, `ADDR_CONTROL=3`, `ADDR_SLAVESEL=5`.
  - Control bit index `CTRL_SSO_BIT=10`.
  - FSM state enum.
- Sub-module `sync_fifo` (8-bit, parameter DEPTH, FWFT, count output), instantiated twice.

## Test plan
- Reset: after reset release, `tx_ready=1`, `rx_valid=0`, `spi_select=0`, `read_n=write_n=1`.
- Single byte: push 0xA5 with a loopback MISO=MOSI SPI master model → exactly one addr-1 write of 0x00A5, then one addr-0 read; `rx_data=0xA5`, `rx_valid` rises; `inflight` returns to 0; SPI master status shows no ROE/TOE.
- Burst: push 0x00..0x0F back-to-back with `rx_ready=1` → 16 bytes returned in order; every access is 2 bus cycles followed by a 1-cycle gap.
- Backpressure: `rx_ready=0`, push 20 bytes with DEPTH=16 → at most 16 writes issued and no ROE; `tx_ready` drops when the TX FIFO fills; after `rx_ready=1`, all 20 bytes arrive in order.
- Priority: `dataavailable` and `readyfordata` both high in IDLE with TX data pending → RD1 issued first.
- Mid-access reset: assert `reset_n=0` during WR2 → bus outputs idle asynchronously, FIFOs empty; with SPI_BRIDGE_CS_HOLD_EN, toggling `cs_hold` 0→1 produces one addr-3 write of 0x0400.
